// File: rtl/video_timing_pkg.sv
// -----------------------------------------------------------------------------
// video_timing_pkg
// Shared constants and helpers for the raster timing generator:
//   - 640x480@60 default timing constants
//   - H_TOTAL / V_TOTAL derivation functions
//   - default sync polarity
//   - 8-entry colour-bar table (24-bit RGB, R in [23:16]) and bar-index helper
// -----------------------------------------------------------------------------
package video_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    // 1 = syncs assert high, 0 = syncs assert low
    localparam bit SYNC_ACT_HIGH_DEF = 1'b1;

    localparam int N_BARS = 8;

    // Element 0 is the leftmost bar: white, yellow, cyan, green,
    // magenta, red, blue, black.
    localparam logic [7:0][23:0] BAR_TABLE = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

    function automatic int h_total_f(input int act, input int fp, input int sw, input int bp);
        return act + fp + sw + bp;
    endfunction

    function automatic int v_total_f(input int act, input int fp, input int sw, input int bp);
        return act + fp + sw + bp;
    endfunction

    // Equal-width bars across the active width; clamps past the right edge.
    function automatic logic [2:0] bar_index(input int col, input int h_active);
        int idx;
        idx = (col * N_BARS) / h_active;
        if (idx > N_BARS - 1) begin
            idx = N_BARS - 1;
        end else begin
            idx = idx;
        end
        return idx[2:0];
    endfunction

endpackage

// File: rtl/video_axis_counter.sv
// -----------------------------------------------------------------------------
// video_axis_counter
// Wrap counter 0..TOTAL-1 for one raster axis, with terminal-count pulse and
// active / sync window decode of the current count.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   clear       synchronous clear to 0 (priority over step)
//   step        advance by one this cycle
//   cnt         current count
//   tc          step && cnt == TOTAL-1 (wrap happens on this edge)
//   in_active   cnt < ACTIVE
//   in_sync     SYNC_START <= cnt < SYNC_END
// -----------------------------------------------------------------------------
module video_axis_counter
    import video_timing_pkg::*;
#(
    parameter int TOTAL      = 800,
    parameter int ACTIVE     = 640,
    parameter int SYNC_START = 656,
    parameter int SYNC_END   = 752,
    parameter int CW         = 13
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          step,
    output logic [CW-1:0] cnt,
    output logic          tc,
    output logic          in_active,
    output logic          in_sync
);

    localparam logic [CW-1:0] LAST_C = CW'(TOTAL - 1);
    localparam logic [CW-1:0] ACT_C  = CW'(ACTIVE);
    localparam logic [CW-1:0] SS_C   = CW'(SYNC_START);
    localparam logic [CW-1:0] SE_C   = CW'(SYNC_END);
    localparam logic [CW-1:0] ONE_C  = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] cnt_r;

    // Axis position: wraps at LAST_C so TOTAL itself is never reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (clear) begin
            cnt_r <= {CW{1'b0}};
        end else if (step) begin
            if (cnt_r == LAST_C) begin
                cnt_r <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + ONE_C;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt       = cnt_r;
    assign tc        = step && (cnt_r == LAST_C);
    assign in_active = (cnt_r < ACT_C);
    assign in_sync   = (cnt_r >= SS_C) && (cnt_r < SE_C);

endmodule

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
// Pixel-clock raster timing source feeding the TMDS encoders.
// Stage 0 registers the request (pix_req/req_x/req_y) and raw syncs from the
// h/v counters; a LEAD-deep shift pipeline then delivers de/syncs/x/y and the
// line/frame pulses so that de(t) == pix_req(t-LEAD).
// Ports:
//   pix_clk, rst_n       pixel clock, async active-low reset
//   enable               run timing; low clears counters and idles outputs
//   pix_req, req_x/y     pixel request, LEAD cycles ahead of de
//   de, hsync, vsync     encoder controls (sync polarity per SYNC_ACT_HIGH)
//   x, y                 coordinates aligned with de
//   line_start           pulse at x==0 of every line
//   frame_start          pulse at x==0, y==0
//   tp_r/g/b             colour-bar pattern, aligned with de, zero when de=0
//                        (present only with VIDEO_TIMING_GEN_PATTERN_EN)
// -----------------------------------------------------------------------------
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE      = H_ACTIVE_DEF,
    parameter int H_FP          = H_FP_DEF,
    parameter int H_SYNC        = H_SYNC_DEF,
    parameter int H_BP          = H_BP_DEF,
    parameter int V_ACTIVE      = V_ACTIVE_DEF,
    parameter int V_FP          = V_FP_DEF,
    parameter int V_SYNC        = V_SYNC_DEF,
    parameter int V_BP          = V_BP_DEF,
    parameter bit SYNC_ACT_HIGH = SYNC_ACT_HIGH_DEF,
    parameter int LEAD          = 1,
    parameter int CW            = 13
) (
    input  logic          pix_clk,
    input  logic          rst_n,
    input  logic          enable,
    output logic          pix_req,
    output logic [CW-1:0] req_x,
    output logic [CW-1:0] req_y,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    ,
    output logic [7:0]    tp_r,
    output logic [7:0]    tp_g,
    output logic [7:0]    tp_b
`endif
);

    localparam int H_TOTAL = h_total_f(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total_f(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic SYNC_IDLE = (SYNC_ACT_HIGH == 1'b0) ? 1'b1 : 1'b0;

    // Stage word layout: {fs, ls, vs, hs, req, y, x}
    localparam int F_X  = 0;
    localparam int F_Y  = CW;
    localparam int F_RQ = 2 * CW;
    localparam int F_HS = 2 * CW + 1;
    localparam int F_VS = 2 * CW + 2;
    localparam int F_LS = 2 * CW + 3;
    localparam int F_FS = 2 * CW + 4;
    localparam int W    = 2 * CW + 5;

    if (LEAD < 1 || LEAD > 4 || H_TOTAL >= (2 ** CW) || V_TOTAL >= (2 ** CW)) begin : g_bad_cfg
        $fatal(1, "video_timing_gen: LEAD must be 1..4 and totals must fit in CW bits");
    end

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          h_tc;
    logic          v_tc_unused;
    logic          h_act;
    logic          v_act;
    logic          h_sync;
    logic          v_sync;

    video_axis_counter #(
        .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE),
        .SYNC_START(H_ACTIVE + H_FP), .SYNC_END(H_ACTIVE + H_FP + H_SYNC), .CW(CW)
    ) u_h_cnt (
        .clk(pix_clk), .rst_n(rst_n), .clear(!enable), .step(1'b1),
        .cnt(h_cnt), .tc(h_tc), .in_active(h_act), .in_sync(h_sync)
    );

    // Vertical axis advances once per line; its own wrap pulse is not needed.
    video_axis_counter #(
        .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE),
        .SYNC_START(V_ACTIVE + V_FP), .SYNC_END(V_ACTIVE + V_FP + V_SYNC), .CW(CW)
    ) u_v_cnt (
        .clk(pix_clk), .rst_n(rst_n), .clear(!enable), .step(h_tc),
        .cnt(v_cnt), .tc(v_tc_unused), .in_active(v_act), .in_sync(v_sync)
    );

    logic [W-1:0]          s0_next;
    logic [W*LEAD-1:0]     pipe_r;
    logic [W*(LEAD+1)-1:0] pipe_cat_s;
    logic [W-1:0]          stage0_s;
    logic [W-1:0]          tail_s;

    // Stage-0 input: coordinates always follow the counters, flags only when enabled.
    always_comb begin
        s0_next = {W{1'b0}};
        s0_next[F_X +: CW] = h_cnt;
        s0_next[F_Y +: CW] = v_cnt;
        if (enable) begin
            s0_next[F_RQ] = h_act && v_act;
            s0_next[F_HS] = h_sync;
            s0_next[F_VS] = v_sync;
            s0_next[F_LS] = (h_cnt == {CW{1'b0}});
            s0_next[F_FS] = (h_cnt == {CW{1'b0}}) && (v_cnt == {CW{1'b0}});
        end else begin
            s0_next[F_RQ] = 1'b0;
            s0_next[F_HS] = 1'b0;
            s0_next[F_VS] = 1'b0;
            s0_next[F_LS] = 1'b0;
            s0_next[F_FS] = 1'b0;
        end
    end

    // Slot 0 is the stage-0 register; higher slots delay it (keeps shifting while idle).
    assign pipe_cat_s = {pipe_r, s0_next};

    // Stage-0 register plus LEAD-1 delay slots.
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_r <= {(W*LEAD){1'b0}};
        end else begin
            pipe_r <= pipe_cat_s[W*LEAD-1:0];
        end
    end

    assign stage0_s = pipe_r[W-1:0];
    assign tail_s   = pipe_r[W*LEAD-1 -: W];

    assign pix_req = stage0_s[F_RQ];
    assign req_x   = stage0_s[F_X +: CW];
    assign req_y   = stage0_s[F_Y +: CW];

    // Output register; sync polarity is applied only here.
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            de          <= 1'b0;
            hsync       <= SYNC_IDLE;
            vsync       <= SYNC_IDLE;
            x           <= {CW{1'b0}};
            y           <= {CW{1'b0}};
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            de          <= tail_s[F_RQ];
            hsync       <= tail_s[F_HS] ^ SYNC_IDLE;
            vsync       <= tail_s[F_VS] ^ SYNC_IDLE;
            x           <= tail_s[F_X +: CW];
            y           <= tail_s[F_Y +: CW];
            line_start  <= tail_s[F_LS];
            frame_start <= tail_s[F_FS];
        end
    end

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    logic [23:0]            bar_s;
    logic [24*LEAD-1:0]     col_r;
    logic [24*(LEAD+1)-1:0] col_cat_s;

    // Bar colour for the requested column; black outside the request window.
    always_comb begin
        if (stage0_s[F_RQ]) begin
            bar_s = BAR_TABLE[bar_index(int'(stage0_s[F_X +: CW]), H_ACTIVE)];
        end else begin
            bar_s = 24'h000000;
        end
    end

    assign col_cat_s = {col_r, bar_s};

    // LEAD-deep colour delay so the top slot lines up with de.
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r <= {(24*LEAD){1'b0}};
        end else begin
            col_r <= col_cat_s[24*LEAD-1:0];
        end
    end

    assign tp_r = col_r[24*LEAD-1 -: 8];
    assign tp_g = col_r[24*LEAD-9 -: 8];
    assign tp_b = col_r[24*LEAD-17 -: 8];
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_video_timing_gen
// Directed bench on a reduced raster (24x10 total, 16x6 active) so whole frames
// stay short. Instance A: LEAD=1, active-high syncs. Instance B: LEAD=3,
// active-low syncs. Both share clock, reset and enable.
// -----------------------------------------------------------------------------
module tb_video_timing_gen;

    localparam int HA = 16;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 3;
    localparam int VA = 6;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int HT = 24;
    localparam int VT = 10;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;

    logic        pix_req_a, de_a, hsync_a, vsync_a, line_start_a, frame_start_a;
    logic [12:0] req_x_a, req_y_a, x_a, y_a;
    logic        pix_req_b, de_b, hsync_b, vsync_b, line_start_b, frame_start_b;
    logic [12:0] req_x_b, req_y_b, x_b, y_b;
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    logic [7:0]  tp_r_a, tp_g_a, tp_b_a, tp_r_b, tp_g_b, tp_b_b;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_ACT_HIGH(1'b1), .LEAD(1), .CW(13)
    ) u_dut_a (
        .pix_clk(clk), .rst_n(rst_n), .enable(enable),
        .pix_req(pix_req_a), .req_x(req_x_a), .req_y(req_y_a),
        .de(de_a), .hsync(hsync_a), .vsync(vsync_a), .x(x_a), .y(y_a),
        .line_start(line_start_a), .frame_start(frame_start_a)
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
        , .tp_r(tp_r_a), .tp_g(tp_g_a), .tp_b(tp_b_a)
`endif
    );

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_ACT_HIGH(1'b0), .LEAD(3), .CW(13)
    ) u_dut_b (
        .pix_clk(clk), .rst_n(rst_n), .enable(enable),
        .pix_req(pix_req_b), .req_x(req_x_b), .req_y(req_y_b),
        .de(de_b), .hsync(hsync_b), .vsync(vsync_b), .x(x_b), .y(y_b),
        .line_start(line_start_b), .frame_start(frame_start_b)
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
        , .tp_r(tp_r_b), .tp_g(tp_g_b), .tp_b(tp_b_b)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
        end
    endtask

    // Release reset between edges, then check the first-edge request.
    task automatic release_reset(input string pfx);
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        check_val({pfx, "_first_req"},  32'(pix_req_a), 32'd1);
        check_val({pfx, "_first_rx"},   32'(req_x_a),   32'd0);
        check_val({pfx, "_first_ry"},   32'(req_y_a),   32'd0);
        check_val({pfx, "_first_de"},   32'(de_a),      32'd0);
        check_val({pfx, "_first_fs"},   32'(frame_start_a), 32'd0);
        check_val({pfx, "_first_req_b"}, 32'(pix_req_b), 32'd1);
    endtask

    // Observe two full frames starting at A's frame_start and check the raster.
    task automatic measure(input string pfx);
        logic        pr_prev, de_prev, hs_prev, vs_prev;
        logic        pb_h [0:2];
        logic [12:0] xb_h [0:2];
        logic [12:0] yb_h [0:2];
        int lag_a = 0, lag_b = 0, de_cnt = 0, hs_cnt = 0, vs_cnt = 0;
        int hsb_low = 0, vsb_low = 0, ls_cnt = 0;
        int run = 0, hi_run = -1, lo_run = -1, last_rise = 0, hs_off = -1;
        int vx = -1, vy = -1, fs_n = 0, fs_t0 = -1, fs_t1 = -1;
        pr_prev = pix_req_a;
        de_prev = de_a;
        hs_prev = hsync_a;
        vs_prev = vsync_a;
        for (int k = 0; k < 3; k++) begin
            pb_h[k] = 1'b0;
            xb_h[k] = 13'd0;
            yb_h[k] = 13'd0;
        end
        for (int i = 0; i < 2 * HT * VT; i++) begin
            @(negedge clk);
            if (de_a !== pr_prev) lag_a++;
            if (i >= 3 && (de_b !== pb_h[2] || x_b !== xb_h[2] || y_b !== yb_h[2])) lag_b++;
            pb_h[2] = pb_h[1]; pb_h[1] = pb_h[0]; pb_h[0] = pix_req_b;
            xb_h[2] = xb_h[1]; xb_h[1] = xb_h[0]; xb_h[0] = req_x_b;
            yb_h[2] = yb_h[1]; yb_h[1] = yb_h[0]; yb_h[0] = req_y_b;
            if (de_a !== de_prev) begin
                if (de_prev && hi_run < 0) hi_run = run;
                if (!de_prev && hi_run >= 0 && lo_run < 0) lo_run = run;
                if (!de_prev) last_rise = i;
                run = 1;
            end else begin
                run++;
            end
            if (hsync_a && !hs_prev && hs_off < 0) hs_off = i - last_rise;
            if (vsync_a && !vs_prev && vx < 0) begin
                vx = int'(x_a);
                vy = int'(y_a);
            end
            if (frame_start_a) begin
                if (fs_n == 0) fs_t0 = i;
                if (fs_n == 1) fs_t1 = i;
                fs_n++;
            end
            de_cnt  += int'(de_a);
            hs_cnt  += int'(hsync_a);
            vs_cnt  += int'(vsync_a);
            ls_cnt  += int'(line_start_a);
            hsb_low += int'(!hsync_b);
            vsb_low += int'(!vsync_b);
            pr_prev = pix_req_a;
            de_prev = de_a;
            hs_prev = hsync_a;
            vs_prev = vsync_a;
        end
        check_val({pfx, "_de_lag_a"},   32'(lag_a),   32'd0);
        check_val({pfx, "_lag3_b"},     32'(lag_b),   32'd0);
        check_val({pfx, "_de_count"},   32'(de_cnt),  32'd192);
        check_val({pfx, "_de_hi_run"},  32'(hi_run),  32'd16);
        check_val({pfx, "_de_lo_run"},  32'(lo_run),  32'd8);
        check_val({pfx, "_hs_count"},   32'(hs_cnt),  32'd60);
        check_val({pfx, "_hs_offset"},  32'(hs_off),  32'd18);
        check_val({pfx, "_vs_count"},   32'(vs_cnt),  32'd96);
        check_val({pfx, "_vs_x"},       32'(vx),      32'd0);
        check_val({pfx, "_vs_y"},       32'(vy),      32'd7);
        check_val({pfx, "_ls_count"},   32'(ls_cnt),  32'd20);
        check_val({pfx, "_fs_count"},   32'(fs_n),    32'd2);
        check_val({pfx, "_fs_first"},   32'(fs_t0),   32'd0);
        check_val({pfx, "_fs_period"},  32'(fs_t1 - fs_t0), 32'd240);
        check_val({pfx, "_hs_low_b"},   32'(hsb_low), 32'd60);
        check_val({pfx, "_vs_low_b"},   32'(vsb_low), 32'd96);
    endtask

    initial begin
        int k;
        rst_n  = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check_val("por_de_a",   32'(de_a),          32'd0);
        check_val("por_hs_a",   32'(hsync_a),       32'd0);
        check_val("por_vs_a",   32'(vsync_a),       32'd0);
        check_val("por_req_a",  32'(pix_req_a),     32'd0);
        check_val("por_fs_a",   32'(frame_start_a), 32'd0);
        check_val("por_hs_b",   32'(hsync_b),       32'd1);
        check_val("por_vs_b",   32'(vsync_b),       32'd1);
        check_val("por_de_b",   32'(de_b),          32'd0);

        release_reset("por");
        measure("run1");

        // Drop enable while A shows x=10, y=3.
        k = 0;
        while (!(x_a == 13'd10 && y_a == 13'd3) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check_val("wait_x10y3", 32'(k < 1000), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        check_val("dis_e1_de_a",  32'(de_a),      32'd1);
        check_val("dis_e1_x_a",   32'(x_a),       32'd11);
        check_val("dis_e1_req_a", 32'(pix_req_a), 32'd0);
        @(negedge clk);
        check_val("dis_e2_de_a",  32'(de_a),      32'd0);
        check_val("dis_e2_rx_a",  32'(req_x_a),   32'd0);
        @(negedge clk);
        check_val("dis_e3_de_b",  32'(de_b),      32'd1);
        @(negedge clk);
        check_val("dis_e4_de_b",  32'(de_b),      32'd0);
        repeat (8) @(negedge clk);
        check_val("idle_req_a",   32'(pix_req_a),     32'd0);
        check_val("idle_de_a",    32'(de_a),          32'd0);
        check_val("idle_fs_a",    32'(frame_start_a), 32'd0);
        check_val("idle_ry_a",    32'(req_y_a),       32'd0);
        check_val("idle_hs_b",    32'(hsync_b),       32'd1);
        check_val("idle_de_b",    32'(de_b),          32'd0);

        enable = 1'b1;
        @(negedge clk);
        check_val("en_e1_req_a",  32'(pix_req_a),     32'd1);
        check_val("en_e1_rx_a",   32'(req_x_a),       32'd0);
        @(negedge clk);
        check_val("en_e2_fs_a",   32'(frame_start_a), 32'd1);
        check_val("en_e2_x_a",    32'(x_a),           32'd0);
        check_val("en_e2_y_a",    32'(y_a),           32'd0);
        check_val("en_e2_de_a",   32'(de_a),          32'd1);
        check_val("en_e2_fs_b",   32'(frame_start_b), 32'd0);
        repeat (2) @(negedge clk);
        check_val("en_e4_fs_b",   32'(frame_start_b), 32'd1);
        check_val("en_e4_x_b",    32'(x_b),           32'd0);
        check_val("en_e4_y_b",    32'(y_b),           32'd0);

        // Asynchronous reset in the middle of an hsync pulse inside vsync.
        k = 0;
        while (!(hsync_a && vsync_a) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check_val("wait_hs_vs", 32'(k < 1000), 32'd1);
        repeat (2) @(negedge clk);
        check_val("pre_hs_a",   32'(hsync_a), 32'd1);
        check_val("pre_hs_b",   32'(hsync_b), 32'd0);
        check_val("pre_vs_b",   32'(vsync_b), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_hs_a",  32'(hsync_a),   32'd0);
        check_val("arst_vs_a",  32'(vsync_a),   32'd0);
        check_val("arst_y_a",   32'(y_a),       32'd0);
        check_val("arst_x_a",   32'(x_a),       32'd0);
        check_val("arst_ry_a",  32'(req_y_a),   32'd0);
        check_val("arst_hs_b",  32'(hsync_b),   32'd1);
        check_val("arst_vs_b",  32'(vsync_b),   32'd1);
        check_val("arst_y_b",   32'(y_b),       32'd0);
        repeat (2) @(negedge clk);
        release_reset("arst");
        measure("run2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
